// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C init sequencer: state encoding, table entry type
// and the default register initialisation table.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_NEXT,
    S_DONE,
    S_RB_REQ,
    S_RB_WAIT
  } seq_state_t;

  typedef struct packed {
    logic [7:0] sub_address;
    logic [7:0] data;
  } seq_entry_t;

  // Entries past the populated table get a recognisable filler pattern.
  function automatic seq_entry_t default_entry(input logic [5:0] idx);
    seq_entry_t e;
    case (idx)
      6'd0:    e = '{sub_address: 8'h1E, data: 8'h00};
      6'd1:    e = '{sub_address: 8'h00, data: 8'h17};
      6'd2:    e = '{sub_address: 8'h02, data: 8'h17};
      6'd3:    e = '{sub_address: 8'h04, data: 8'h79};
      6'd4:    e = '{sub_address: 8'h06, data: 8'h79};
      6'd5:    e = '{sub_address: 8'h08, data: 8'h12};
      6'd6:    e = '{sub_address: 8'h0A, data: 8'h00};
      6'd7:    e = '{sub_address: 8'h0C, data: 8'h00};
      6'd8:    e = '{sub_address: 8'h0E, data: 8'h4A};
      6'd9:    e = '{sub_address: 8'h10, data: 8'h00};
      6'd10:   e = '{sub_address: 8'h12, data: 8'h01};
      6'd11:   e = '{sub_address: 8'h20, data: 8'hA5};
      6'd12:   e = '{sub_address: 8'h22, data: 8'h5A};
      6'd13:   e = '{sub_address: 8'h24, data: 8'h3C};
      6'd14:   e = '{sub_address: 8'h26, data: 8'hC3};
      6'd15:   e = '{sub_address: 8'h28, data: 8'hFF};
      default: e = '{sub_address: {2'b10, idx}, data: 8'h00};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/i2c_seq_rom.sv
// Init table lookup: entry_idx -> {sub_address, data}; out-of-range indices read as zero.
module i2c_seq_rom
  import i2c_seq_pkg::*;
#(
  parameter int NUM_ENTRIES = 16
) (
  input  logic [5:0] idx,
  output seq_entry_t entry
);

  always_comb begin
    entry = '0;
    if (int'(idx) < NUM_ENTRIES) entry = default_entry(idx);
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init table, issuing one single-byte I2C write per entry to DEV_ADDR.
// Define I2C_SEQ_READBACK_EN to add a verifying read after every write.
module i2c_init_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h20,
  parameter int         NUM_ENTRIES = 16,
  parameter int         REQ_TIMEOUT = 4096
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       start,
  input  logic       i2c_busy,
  input  logic       i2c_de,
  input  logic [7:0] i2c_rx,
  output logic       i2c_request,
  output logic       i2c_wr,
  output logic [7:0] i2c_length,
  output logic [6:0] i2c_address,
  output logic [7:0] i2c_sub_address,
  output logic [7:0] i2c_tx,
  output logic       seq_busy,
  output logic       done,
  output logic       timeout_err,
  output logic [5:0] entry_idx
`ifdef I2C_SEQ_READBACK_EN
  ,
  output logic [7:0] mismatch_cnt
`endif
);

  localparam int            TW       = $clog2(REQ_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX     = TW'(REQ_TIMEOUT - 1);
  localparam logic [5:0]    LAST_IDX = 6'(NUM_ENTRIES - 1);

  seq_state_t    state, state_nxt;
  seq_entry_t    rom_entry;
  logic [1:0]    busy_sync;
  logic          busy_s;
  logic [TW-1:0] tmo_cnt;
  logic          req_timeout;

  assign i2c_length  = 8'd1;
  assign i2c_address = DEV_ADDR;
  assign busy_s      = busy_sync[1];
  assign seq_busy    = (state != S_IDLE) && (state != S_DONE);
  assign req_timeout = i2c_request && !busy_s && (tmo_cnt == TMAX);

  i2c_seq_rom #(.NUM_ENTRIES(NUM_ENTRIES)) u_rom (
    .idx   (entry_idx),
    .entry (rom_entry)
  );

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) busy_sync <= '0;
    else          busy_sync <= {busy_sync[0], i2c_busy};
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n)                  tmo_cnt <= '0;
    else if (i2c_request && !busy_s) tmo_cnt <= tmo_cnt + TW'(1);
    else                           tmo_cnt <= '0;
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    i2c_request = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_REQ;
      S_REQ: begin
        i2c_request = 1'b1;
        if (busy_s)               state_nxt = S_WAIT;
        else if (tmo_cnt == TMAX) state_nxt = S_DONE;
      end
      S_WAIT: if (!busy_s) begin
`ifdef I2C_SEQ_READBACK_EN
        state_nxt = S_RB_REQ;
`else
        state_nxt = S_NEXT;
`endif
      end
      S_NEXT: state_nxt = (entry_idx == LAST_IDX) ? S_DONE : S_LOAD;
      S_DONE: state_nxt = S_IDLE;
`ifdef I2C_SEQ_READBACK_EN
      S_RB_REQ: begin
        i2c_request = 1'b1;
        if (busy_s)               state_nxt = S_RB_WAIT;
        else if (tmo_cnt == TMAX) state_nxt = S_DONE;
      end
      S_RB_WAIT: if (!busy_s) state_nxt = S_NEXT;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address, data and direction are held from LOAD until the entry's transactions finish.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      entry_idx       <= '0;
      done            <= 1'b0;
      timeout_err     <= 1'b0;
      i2c_sub_address <= '0;
      i2c_tx          <= '0;
      i2c_wr          <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        entry_idx   <= '0;
        done        <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (state == S_LOAD) begin
        i2c_sub_address <= rom_entry.sub_address;
        i2c_tx          <= rom_entry.data;
        i2c_wr          <= 1'b1;
      end
      if (state == S_NEXT && entry_idx != LAST_IDX) entry_idx <= entry_idx + 6'd1;
      if (state != S_DONE && state_nxt == S_DONE) done <= 1'b1;
      if (req_timeout) timeout_err <= 1'b1;
`ifdef I2C_SEQ_READBACK_EN
      if (state == S_WAIT && state_nxt == S_RB_REQ) i2c_wr <= 1'b0;
`endif
    end
  end

`ifdef I2C_SEQ_READBACK_EN
  logic [2:0] de_sync;
  logic       de_rise;

  assign de_rise = de_sync[1] && !de_sync[2];

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) de_sync <= '0;
    else          de_sync <= {de_sync[1:0], i2c_de};
  end

  // i2c_rx is only trusted once the synchronised data-enable edge arrives.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      mismatch_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      mismatch_cnt <= '0;
    end else if (state == S_RB_WAIT && de_rise && (i2c_rx != i2c_tx) && (mismatch_cnt != 8'hFF)) begin
      mismatch_cnt <= mismatch_cnt + 8'd1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{i2c_de, i2c_rx};
`endif

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: behavioural I2C master with random response timing,
// checked against the expected transaction list derived from the init table.
`timescale 1ns/1ps
module tb_i2c_init_sequencer;

  localparam int TIMEOUT = 4096;
`ifdef I2C_SEQ_READBACK_EN
  localparam int TPE = 2;
`else
  localparam int TPE = 1;
`endif

  logic       clk_50  = 1'b0;
  logic       reset_n = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       i2c_busy = 1'b0;
  logic       i2c_de   = 1'b0;
  logic [7:0] i2c_rx   = 8'h00;

  logic       req_a, wr_a, sbusy_a, done_a, terr_a;
  logic [7:0] len_a, sub_a, tx_a;
  logic [6:0] addr_a;
  logic [5:0] idx_a;
  logic       req_b, wr_b, sbusy_b, done_b, terr_b;
  logic [7:0] len_b, sub_b, tx_b;
  logic [6:0] addr_b;
  logic [5:0] idx_b;
`ifdef I2C_SEQ_READBACK_EN
  logic [7:0] mm_a, mm_b;
`endif

  logic [15:0] tab [16] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                            16'h0A00, 16'h0C00, 16'h0E4A, 16'h1000, 16'h1201, 16'h20A5,
                            16'h225A, 16'h243C, 16'h26C3, 16'h28FF};
  logic [16:0] log_q [$];
  bit   model_en = 1'b1;
  bit   sel_b    = 1'b0;
  int   busy_len = 40;
  int   req_cycles = 0;
  int   req_edges  = 0;
  logic req_prev   = 1'b0;
  int   tests    = 0;
  int   failures = 0;

  logic       model_req, model_wr, sel_done, sel_sbusy;
  logic [7:0] model_sub, model_tx;
  assign model_req = sel_b ? req_b : req_a;
  assign model_wr  = sel_b ? wr_b  : wr_a;
  assign model_sub = sel_b ? sub_b : sub_a;
  assign model_tx  = sel_b ? tx_b  : tx_a;
  assign sel_done  = sel_b ? done_b : done_a;
  assign sel_sbusy = sel_b ? sbusy_b : sbusy_a;

  i2c_init_sequencer #(.DEV_ADDR(7'h20), .NUM_ENTRIES(16), .REQ_TIMEOUT(TIMEOUT)) dut_a (
    .clk_50(clk_50), .reset_n(reset_n), .start(start_a), .i2c_busy(i2c_busy),
    .i2c_de(i2c_de), .i2c_rx(i2c_rx), .i2c_request(req_a), .i2c_wr(wr_a),
    .i2c_length(len_a), .i2c_address(addr_a), .i2c_sub_address(sub_a), .i2c_tx(tx_a),
    .seq_busy(sbusy_a), .done(done_a), .timeout_err(terr_a), .entry_idx(idx_a)
`ifdef I2C_SEQ_READBACK_EN
    , .mismatch_cnt(mm_a)
`endif
  );

  i2c_init_sequencer #(.DEV_ADDR(7'h20), .NUM_ENTRIES(1), .REQ_TIMEOUT(TIMEOUT)) dut_b (
    .clk_50(clk_50), .reset_n(reset_n), .start(start_b), .i2c_busy(i2c_busy),
    .i2c_de(i2c_de), .i2c_rx(i2c_rx), .i2c_request(req_b), .i2c_wr(wr_b),
    .i2c_length(len_b), .i2c_address(addr_b), .i2c_sub_address(sub_b), .i2c_tx(tx_b),
    .seq_busy(sbusy_b), .done(done_b), .timeout_err(terr_b), .entry_idx(idx_b)
`ifdef I2C_SEQ_READBACK_EN
    , .mismatch_cnt(mm_b)
`endif
  );

  always #10 clk_50 = ~clk_50;

  always @(negedge clk_50) begin
    req_prev <= model_req;
    if (model_req) req_cycles <= req_cycles + 1;
    if (model_req && !req_prev) req_edges <= req_edges + 1;
  end

  // Master model: answers each request after a random delay, logs {wr, sub, tx}.
  // Reads return the last written byte, corrupted for sub-addresses 0x02 and 0x0C.
  initial begin : master_model
    logic [7:0] last_wr;
    logic [7:0] rd_val;
    logic       t_wr;
    int         hold;
    last_wr = 8'h00;
    forever begin
      @(negedge clk_50);
      if (model_en && model_req) begin
        repeat ($urandom_range(0, 3)) @(negedge clk_50);
        log_q.push_back({model_wr, model_sub, model_tx});
        t_wr   = model_wr;
        hold   = busy_len;
        rd_val = last_wr ^ (((model_sub == 8'h02) || (model_sub == 8'h0C)) ? 8'h01 : 8'h00);
        if (t_wr) last_wr = model_tx;
        i2c_busy = 1'b1;
        repeat (hold / 2) @(negedge clk_50);
        if (!t_wr) begin
          i2c_rx = rd_val;
          @(negedge clk_50);
          i2c_de = 1'b1;
          repeat (4) @(negedge clk_50);
          i2c_de = 1'b0;
        end
        repeat (hold - hold / 2) @(negedge clk_50);
        i2c_busy = 1'b0;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_50);
    if (sel_b) start_b = 1'b1;
    else       start_a = 1'b1;
    @(negedge clk_50);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic apply_stimulus(input int budget, input bit inject);
    int cyc;
    cyc = 0;
    pulse_start();
    while (!sel_done && cyc < budget) begin
      @(negedge clk_50);
      cyc++;
      if (inject && sel_sbusy && !model_req && i2c_busy && $urandom_range(0, 7) == 0) begin
        if (sel_b) start_b = 1'b1;
        else       start_a = 1'b1;
        @(negedge clk_50);
        cyc++;
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
    check_output("walk_finished", 32'(sel_done), 32'd1);
  endtask

  task automatic wait_model_idle();
    int cyc;
    cyc = 0;
    repeat (8) @(negedge clk_50);
    while (i2c_busy && cyc < 200) begin
      @(negedge clk_50);
      cyc++;
    end
    check_output("master_idle", 32'(i2c_busy), 32'd0);
  endtask

  task automatic compare_walk(input int base, input int n);
    check_output("txn_count", 32'(log_q.size() - base), 32'(n * TPE));
    for (int i = 0; i < n; i++) begin
      check_output($sformatf("write_%0d", i), 32'(log_q[base + i * TPE]), 32'({1'b1, tab[i]}));
      if (TPE == 2)
        check_output($sformatf("read_%0d", i), 32'(log_q[base + i * TPE + 1]), 32'({1'b0, tab[i]}));
    end
  endtask

  initial begin : watchdog
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int rc0;
    int re0;
    int cyc;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk_50);
    check_output("rst_request", 32'(req_a), 32'd0);
    check_output("rst_wr", 32'(wr_a), 32'd0);
    check_output("rst_length", 32'(len_a), 32'd1);
    check_output("rst_address", 32'(addr_a), 32'h20);
    check_output("rst_sub", 32'(sub_a), 32'd0);
    check_output("rst_tx", 32'(tx_a), 32'd0);
    check_output("rst_flags", 32'({sbusy_a, done_a, terr_a}), 32'd0);
    check_output("rst_idx", 32'(idx_a), 32'd0);
    check_output("rst_b_request", 32'(req_b), 32'd0);
    check_output("rst_b_address", 32'(addr_b), 32'h20);
    reset_n = 1'b1;

    // Full walk with 40-cycle busy and start pulses sprinkled into WAIT.
    base = log_q.size();
    apply_stimulus(8000, 1'b1);
    check_output("walk1_done", 32'(done_a), 32'd1);
    check_output("walk1_idx", 32'(idx_a), 32'd15);
    check_output("walk1_timeout_err", 32'(terr_a), 32'd0);
    check_output("walk1_seq_busy", 32'(sbusy_a), 32'd0);
    compare_walk(base, 16);
`ifdef I2C_SEQ_READBACK_EN
    check_output("walk1_mismatch_cnt", 32'(mm_a), 32'd2);
`endif

    // Start held only during the DONE cycle must not launch a walk.
    start_a = 1'b1;
    @(negedge clk_50);
    start_a = 1'b0;
    repeat (4) @(negedge clk_50);
    check_output("start_in_done_ignored", 32'(sbusy_a), 32'd0);
    check_output("done_level_held", 32'(done_a), 32'd1);

    for (int w = 0; w < 2; w++) begin
      busy_len = $urandom_range(20, 60);
      base = log_q.size();
      apply_stimulus(9000, 1'b1);
      check_output($sformatf("rand%0d_idx", w), 32'(idx_a), 32'd15);
      compare_walk(base, 16);
    end
    busy_len = 40;

    // Master never answers: exactly one request, held for the full timeout.
    model_en = 1'b0;
    base = log_q.size();
    rc0 = req_cycles;
    re0 = req_edges;
    apply_stimulus(TIMEOUT + 200, 1'b0);
    repeat (3) @(negedge clk_50);
    check_output("tmo_request_cycles", 32'(req_cycles - rc0), 32'(TIMEOUT));
    check_output("tmo_request_count", 32'(req_edges - re0), 32'd1);
    check_output("tmo_timeout_err", 32'(terr_a), 32'd1);
    check_output("tmo_done", 32'(done_a), 32'd1);
    check_output("tmo_idx", 32'(idx_a), 32'd0);
    check_output("tmo_sub", 32'(sub_a), 32'(tab[0][15:8]));
    check_output("tmo_no_txn", 32'(log_q.size() - base), 32'd0);
    model_en = 1'b1;

    // Reset while waiting on entry 5.
    base = log_q.size();
    pulse_start();
    cyc = 0;
    while (!(log_q.size() >= base + 5 * TPE + 1 && i2c_busy) && cyc < 6000) begin
      @(negedge clk_50);
      cyc++;
    end
    repeat (5) @(negedge clk_50);
    check_output("wait5_idx", 32'(idx_a), 32'd5);
    check_output("wait5_request", 32'(req_a), 32'd0);
    #3 reset_n = 1'b0;
    #1;
    check_output("rst_wait_request", 32'(req_a), 32'd0);
    check_output("rst_wait_idx", 32'(idx_a), 32'd0);
    check_output("rst_wait_flags", 32'({sbusy_a, done_a, terr_a}), 32'd0);
    @(negedge clk_50);
    reset_n = 1'b1;
    wait_model_idle();

    // Reset while a request is outstanding drops it at once.
    pulse_start();
    cyc = 0;
    while (!req_a && cyc < 50) begin
      @(negedge clk_50);
      cyc++;
    end
    check_output("req_seen", 32'(req_a), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check_output("rst_req_request", 32'(req_a), 32'd0);
    @(negedge clk_50);
    reset_n = 1'b1;
    wait_model_idle();

    base = log_q.size();
    apply_stimulus(8000, 1'b0);
    compare_walk(base, 16);

    // Single-entry table.
    sel_b = 1'b1;
    base = log_q.size();
    re0 = req_edges;
    apply_stimulus(3000, 1'b0);
    repeat (3) @(negedge clk_50);
    check_output("one_done", 32'(done_b), 32'd1);
    check_output("one_idx", 32'(idx_b), 32'd0);
    check_output("one_timeout_err", 32'(terr_b), 32'd0);
    check_output("one_request_count", 32'(req_edges - re0), 32'(TPE));
    compare_walk(base, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
